// File: rtl/ahb_arbiter.sv
// Two-master AHB arbiter: round-robin grant selection, fixed-length burst
// protection, locked-sequence hold and address/data-phase owner tracking.
module ahb_arbiter #(
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic       hclk,
    input  logic       hreset,
    input  logic       hbusreq_0,
    input  logic       hbusreq_1,
    input  logic       hlock_0,
    input  logic       hlock_1,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    input  logic       hready,
    output logic       hgrant_0,
    output logic       hgrant_1,
    output logic       hmaster,
    output logic       hmaster_data,
    output logic       hmastlock
);

    localparam logic       DEF_M        = (DEFAULT_MASTER != 0);
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    // Beat count of a burst type; 0 marks undefined-length INCR.
    function automatic logic [4:0] burst_len(input logic [2:0] burst);
        logic [4:0] len;
        case (burst)
            3'b000:         len = 5'd1;
            3'b001:         len = 5'd0;
            3'b010, 3'b011: len = 5'd4;
            3'b100, 3'b101: len = 5'd8;
            default:        len = 5'd16;
        endcase
        return len;
    endfunction

    logic       g;
    logic       g_next;
    logic [4:0] beats_left;
    logic [4:0] beats_next;
    logic [4:0] len;
    logic       lock_hold;
    logic       arb_ok;

    // The grant register is the pair of complementary grant flops.
    assign g = hgrant_1;

    // Remaining-beat count as it will stand after this edge.
    always_comb begin
        len        = burst_len(hburst);
        beats_next = beats_left;
        if (hready) begin
            if (htrans == TRANS_NONSEQ) begin
                beats_next = (len == 5'd0) ? 5'd0 : len - 5'd1;
            end else if ((htrans == TRANS_SEQ) && (beats_left != 5'd0)) begin
                beats_next = beats_left - 5'd1;
            end
        end
    end

    // Arbitration is allowed once the burst is on its last beat and no lock is held.
    always_comb begin
        lock_hold = g ? hlock_1 : hlock_0;
        arb_ok    = !lock_hold && (beats_next <= 5'd1);
        g_next    = g;
        if (arb_ok) begin
            case ({hbusreq_1, hbusreq_0})
                2'b00:   g_next = DEF_M;
                2'b01:   g_next = 1'b0;
                2'b10:   g_next = 1'b1;
                default: g_next = !g;
            endcase
        end
    end

    // Grant and beat-tracking registers; reset overrides any burst or lock.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            hgrant_1   <= DEF_M;
            hgrant_0   <= !DEF_M;
            beats_left <= 5'd0;
        end else begin
            hgrant_1   <= g_next;
            hgrant_0   <= !g_next;
            beats_left <= beats_next;
        end
    end

    // Owner handover only on completed transfers so a wait-stated slave sees a stable owner.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            hmaster      <= DEF_M;
            hmaster_data <= DEF_M;
            hmastlock    <= 1'b0;
        end else if (hready) begin
            hmaster      <= g;
            hmastlock    <= lock_hold;
            hmaster_data <= hmaster;
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed testbench for ahb_arbiter: two instances (default master 0 and 1)
// share stimulus; each scenario task drives a table of cycles and checks
// {hgrant_1, hgrant_0, hmaster, hmaster_data, hmastlock} after every edge.
module tb_ahb_arbiter;

    localparam logic [1:0] IDL  = 2'b00;
    localparam logic [1:0] NSQ  = 2'b10;
    localparam logic [1:0] SQ   = 2'b11;
    localparam logic [2:0] SGL  = 3'b000;
    localparam logic [2:0] INC4 = 3'b011;
    localparam logic [2:0] INC8 = 3'b101;

    typedef struct packed {
        logic       r0;
        logic       r1;
        logic       l0;
        logic       l1;
        logic [1:0] tr;
        logic [2:0] bu;
        logic       rdy;
        logic       rst;
        logic [4:0] exp;
    } row_t;

    logic       hclk;
    logic       hreset;
    logic       hbusreq_0, hbusreq_1;
    logic       hlock_0, hlock_1;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;

    logic hgrant_0_a, hgrant_1_a, hmaster_a, hmaster_data_a, hmastlock_a;
    logic hgrant_0_b, hgrant_1_b, hmaster_b, hmaster_data_b, hmastlock_b;
    logic [4:0] obs_a;
    logic [4:0] obs_b;

    int n_cmp;
    int n_fail;

    assign obs_a = {hgrant_1_a, hgrant_0_a, hmaster_a, hmaster_data_a, hmastlock_a};
    assign obs_b = {hgrant_1_b, hgrant_0_b, hmaster_b, hmaster_data_b, hmastlock_b};

    ahb_arbiter #(.DEFAULT_MASTER(0)) dut_a (
        .hclk(hclk), .hreset(hreset),
        .hbusreq_0(hbusreq_0), .hbusreq_1(hbusreq_1),
        .hlock_0(hlock_0), .hlock_1(hlock_1),
        .htrans(htrans), .hburst(hburst), .hready(hready),
        .hgrant_0(hgrant_0_a), .hgrant_1(hgrant_1_a),
        .hmaster(hmaster_a), .hmaster_data(hmaster_data_a), .hmastlock(hmastlock_a)
    );

    ahb_arbiter #(.DEFAULT_MASTER(1)) dut_b (
        .hclk(hclk), .hreset(hreset),
        .hbusreq_0(hbusreq_0), .hbusreq_1(hbusreq_1),
        .hlock_0(hlock_0), .hlock_1(hlock_1),
        .htrans(htrans), .hburst(hburst), .hready(hready),
        .hgrant_0(hgrant_0_b), .hgrant_1(hgrant_1_b),
        .hmaster(hmaster_b), .hmaster_data(hmaster_data_b), .hmastlock(hmastlock_b)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Apply one cycle of inputs, let the edge happen, settle 1 time unit.
    task automatic drive_step(input row_t r);
        hbusreq_0 = r.r0;
        hbusreq_1 = r.r1;
        hlock_0   = r.l0;
        hlock_1   = r.l1;
        htrans    = r.tr;
        hburst    = r.bu;
        hready    = r.rdy;
        hreset    = r.rst;
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        drive_step('{1'b0, 1'b0, 1'b0, 1'b0, IDL, SGL, 1'b1, 1'b1, 5'b00000});
    endtask

    task automatic test_reset();
        do_reset();
        if (obs_a !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_def0 got %b want %b", obs_a, 5'b01000);
        end
        n_cmp++;
        if (obs_b !== 5'b10110) begin
            n_fail++;
            $display("FAIL reset_def1 got %b want %b", obs_b, 5'b10110);
        end
        n_cmp++;
    endtask

    task automatic test_default();
        row_t       tbl [2];
        logic [4:0] exp_b [2];
        do_reset();
        tbl = '{
            '{1'b1, 1'b0, 1'b0, 1'b0, IDL, SGL, 1'b1, 1'b0, 5'b01000},
            '{1'b0, 1'b0, 1'b0, 1'b0, IDL, SGL, 1'b1, 1'b0, 5'b01000}
        };
        exp_b = '{5'b01110, 5'b10010};
        for (int i = 0; i < 2; i++) begin
            drive_step(tbl[i]);
            if (obs_a !== tbl[i].exp) begin
                n_fail++;
                $display("FAIL default_a[%0d] got %b want %b", i, obs_a, tbl[i].exp);
            end
            n_cmp++;
            if (obs_b !== exp_b[i]) begin
                n_fail++;
                $display("FAIL default_b[%0d] got %b want %b", i, obs_b, exp_b[i]);
            end
            n_cmp++;
        end
    endtask

    task automatic test_round_robin();
        row_t tbl [6];
        do_reset();
        tbl = '{
            '{1'b1, 1'b1, 1'b0, 1'b0, NSQ, SGL, 1'b1, 1'b0, 5'b10000},
            '{1'b1, 1'b1, 1'b0, 1'b0, NSQ, SGL, 1'b1, 1'b0, 5'b01100},
            '{1'b1, 1'b1, 1'b0, 1'b0, NSQ, SGL, 1'b1, 1'b0, 5'b10010},
            '{1'b1, 1'b1, 1'b0, 1'b0, NSQ, SGL, 1'b1, 1'b0, 5'b01100},
            '{1'b1, 1'b1, 1'b0, 1'b0, NSQ, SGL, 1'b1, 1'b0, 5'b10010},
            '{1'b1, 1'b1, 1'b0, 1'b0, NSQ, SGL, 1'b1, 1'b0, 5'b01100}
        };
        for (int i = 0; i < 6; i++) begin
            drive_step(tbl[i]);
            if (obs_a !== tbl[i].exp) begin
                n_fail++;
                $display("FAIL round_robin[%0d] got %b want %b", i, obs_a, tbl[i].exp);
            end
            n_cmp++;
        end
    endtask

    task automatic test_incr4();
        row_t tbl [5];
        do_reset();
        tbl = '{
            '{1'b1, 1'b1, 1'b0, 1'b0, NSQ, INC4, 1'b1, 1'b0, 5'b01000},
            '{1'b1, 1'b1, 1'b0, 1'b0, SQ,  INC4, 1'b1, 1'b0, 5'b01000},
            '{1'b1, 1'b1, 1'b0, 1'b0, SQ,  INC4, 1'b1, 1'b0, 5'b10000},
            '{1'b0, 1'b1, 1'b0, 1'b0, SQ,  INC4, 1'b1, 1'b0, 5'b10100},
            '{1'b0, 1'b1, 1'b0, 1'b0, NSQ, SGL,  1'b1, 1'b0, 5'b10110}
        };
        for (int i = 0; i < 5; i++) begin
            drive_step(tbl[i]);
            if (obs_a !== tbl[i].exp) begin
                n_fail++;
                $display("FAIL incr4[%0d] got %b want %b", i, obs_a, tbl[i].exp);
            end
            n_cmp++;
        end
    endtask

    task automatic test_incr4_wait();
        row_t tbl [8];
        do_reset();
        tbl = '{
            '{1'b1, 1'b1, 1'b0, 1'b0, NSQ, INC4, 1'b1, 1'b0, 5'b01000},
            '{1'b1, 1'b1, 1'b0, 1'b0, SQ,  INC4, 1'b0, 1'b0, 5'b01000},
            '{1'b1, 1'b1, 1'b0, 1'b0, SQ,  INC4, 1'b0, 1'b0, 5'b01000},
            '{1'b1, 1'b1, 1'b0, 1'b0, SQ,  INC4, 1'b1, 1'b0, 5'b01000},
            '{1'b1, 1'b1, 1'b0, 1'b0, SQ,  INC4, 1'b1, 1'b0, 5'b10000},
            '{1'b0, 1'b1, 1'b0, 1'b0, SQ,  INC4, 1'b0, 1'b0, 5'b10000},
            '{1'b0, 1'b1, 1'b0, 1'b0, SQ,  INC4, 1'b1, 1'b0, 5'b10100},
            '{1'b0, 1'b1, 1'b0, 1'b0, NSQ, SGL,  1'b1, 1'b0, 5'b10110}
        };
        for (int i = 0; i < 8; i++) begin
            drive_step(tbl[i]);
            if (obs_a !== tbl[i].exp) begin
                n_fail++;
                $display("FAIL incr4_wait[%0d] got %b want %b", i, obs_a, tbl[i].exp);
            end
            n_cmp++;
        end
    endtask

    task automatic test_lock();
        row_t tbl [6];
        do_reset();
        tbl = '{
            '{1'b0, 1'b1, 1'b0, 1'b1, IDL, SGL, 1'b1, 1'b0, 5'b10000},
            '{1'b1, 1'b1, 1'b0, 1'b1, IDL, SGL, 1'b1, 1'b0, 5'b10101},
            '{1'b1, 1'b1, 1'b0, 1'b1, NSQ, SGL, 1'b1, 1'b0, 5'b10111},
            '{1'b1, 1'b1, 1'b0, 1'b1, NSQ, SGL, 1'b1, 1'b0, 5'b10111},
            '{1'b1, 1'b1, 1'b0, 1'b0, IDL, SGL, 1'b1, 1'b0, 5'b01110},
            '{1'b1, 1'b0, 1'b0, 1'b0, IDL, SGL, 1'b1, 1'b0, 5'b01010}
        };
        for (int i = 0; i < 6; i++) begin
            drive_step(tbl[i]);
            if (obs_a !== tbl[i].exp) begin
                n_fail++;
                $display("FAIL lock[%0d] got %b want %b", i, obs_a, tbl[i].exp);
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset_mid_burst();
        row_t       tbl [7];
        logic [4:0] exp_beats [7];
        do_reset();
        tbl = '{
            '{1'b0, 1'b1, 1'b0, 1'b0, IDL, SGL,  1'b1, 1'b0, 5'b10000},
            '{1'b0, 1'b1, 1'b0, 1'b0, IDL, SGL,  1'b1, 1'b0, 5'b10100},
            '{1'b0, 1'b1, 1'b0, 1'b0, NSQ, INC8, 1'b1, 1'b0, 5'b10110},
            '{1'b0, 1'b1, 1'b0, 1'b0, SQ,  INC8, 1'b1, 1'b0, 5'b10110},
            '{1'b0, 1'b1, 1'b0, 1'b0, SQ,  INC8, 1'b1, 1'b0, 5'b10110},
            '{1'b0, 1'b1, 1'b0, 1'b0, SQ,  INC8, 1'b1, 1'b1, 5'b01000},
            '{1'b0, 1'b1, 1'b0, 1'b0, IDL, SGL,  1'b1, 1'b0, 5'b10000}
        };
        exp_beats = '{5'd0, 5'd0, 5'd7, 5'd6, 5'd5, 5'd0, 5'd0};
        for (int i = 0; i < 7; i++) begin
            drive_step(tbl[i]);
            if (obs_a !== tbl[i].exp) begin
                n_fail++;
                $display("FAIL rst_mid_burst[%0d] got %b want %b", i, obs_a, tbl[i].exp);
            end
            n_cmp++;
            if (dut_a.beats_left !== exp_beats[i]) begin
                n_fail++;
                $display("FAIL rst_mid_beats[%0d] got %0d want %0d", i, dut_a.beats_left, exp_beats[i]);
            end
            n_cmp++;
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        hreset    = 1'b1;
        hbusreq_0 = 1'b0;
        hbusreq_1 = 1'b0;
        hlock_0   = 1'b0;
        hlock_1   = 1'b0;
        htrans    = IDL;
        hburst    = SGL;
        hready    = 1'b1;
        #2;
        test_reset();
        test_default();
        test_round_robin();
        test_incr4();
        test_incr4_wait();
        test_lock();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Two-master AHB bus arbiter with round-robin priority, fixed-length burst protection and locked-transfer support. It sits between the two bus masters and the shared address/control mux feeding the slave decoder. It drives the per-master grants, the address-phase owner select and the data-phase owner select for the response mux.

## Interface
Parameters:
- DEFAULT_MASTER, 0, master index granted when no master requests (0 or 1)

Ports:
- hclk  input  1  bus clock, all state updates on rising edge
- hreset  input  1  synchronous, active-high reset
- hbusreq_0, hbusreq_1  input  1 each  bus request from master 0 / 1
- hlock_0, hlock_1  input  1 each  locked-sequence request from master 0 / 1
- htrans  input  2  transfer type of current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- hburst  input  3  burst type of current address-phase owner (000 SINGLE, 001 INCR, 010/011 WRAP4/INCR4, 100/101 WRAP8/INCR8, 110/111 WRAP16/INCR16)
- hready  input  1  transfer-complete from the slave mux
- hgrant_0, hgrant_1  output  1 each  grant to master 0 / 1, registered, exactly one high at all times
- hmaster  output  1  address-phase owner index
- hmaster_data  output  1  data-phase owner index
- hmastlock  output  1  current address phase is part of a locked sequence

## Operation
- State: grant register g (1 bit), hmaster, hmaster_data, hmastlock, beats_left (5 bits, 0..15).
- Burst length len from hburst: SINGLE 1; WRAP4/INCR4 4; WRAP8/INCR8 8; WRAP16/INCR16 16; INCR 0 (undefined length, never blocks arbitration).
- Beat tracking, on each edge with hready=1:
  - htrans=NONSEQ: beats_left <= (len==0) ? 0 : len-1.
  - htrans=SEQ and beats_left!=0: beats_left <= beats_left-1.
  - IDLE/BUSY: beats_left unchanged.
  - hready=0: beats_left holds.
- beats_next is the value beats_left takes at this edge.
- lock_hold = hlock of the currently granted master (hlock_g) is high. A locked owner keeps the grant regardless of other requests.
- arb_ok = !lock_hold && (beats_next <= 1).
- Grant selection when arb_ok (evaluated every cycle, applied at the edge):
  - No requests: g <= DEFAULT_MASTER.
  - Exactly one request: g <= that master.
  - Both request: g <= !g, i.e. round-robin alternation. The current holder yields whenever the other requests.
- When arb_ok=0, g holds.
- Ownership handover, on each edge with hready=1:
  - hmaster <= g.
  - hmastlock <= hlock_g.
  - hmaster_data <= hmaster.
- With hready=0, hmaster, hmastlock and hmaster_data hold. A wait-stated slave therefore never sees an owner change mid-transfer.
- Reset (hreset=1 at an edge) overrides everything, including mid-burst and mid-lock:
  - hgrant_DEFAULT_MASTER=1, the other grant 0.
  - hmaster=hmaster_data=DEFAULT_MASTER.
  - hmastlock=0, beats_left=0.

## Timing
- hgrant_x is a direct register output with no combinational path from inputs.
- Request-to-grant latency:
  - Idle bus: 1 cycle (request sampled at edge N, grant high after edge N).
  - Grant-to-hmaster: next edge with hready=1.
- Fixed bursts: grant moves at the edge accepting the second-to-last beat. Last beat address issued by old owner; new owner's NONSEQ is in the following cycle. No idle cycle inserted.
- INCR bursts: re-arbitration allowed at any edge. The losing master must restart with NONSEQ.
- Simultaneous request and release by the same master in the cycle its grant would be removed: grant still moves only per the arb_ok rule.
- hmaster_data trails hmaster by exactly one hready=1 edge.

## Test plan
- Reset with DEFAULT_MASTER=1: after hreset edge, hgrant_1=1, hgrant_0=0, hmaster=1, hmaster_data=1, hmastlock=0.
- Both masters hold hbusreq with hburst=SINGLE, htrans=NONSEQ every cycle, hready=1: grants alternate 0,1,0,1 each cycle; hmaster follows one cycle later; hmaster_data one cycle after that.
- Master 0 issues INCR4 (NONSEQ+3 SEQ, hready=1) with master 1 requesting throughout: hgrant_1 rises at edge accepting beat 3. hmaster=0 for all four address phases, then 1.
- Same INCR4 with hready=0 for two cycles on beat 2: grant switch delayed by exactly two cycles; hmaster never changes while hready=0.
- Master 1 granted with hlock_1=1 over two SINGLE transfers while master 0 requests: hgrant_1 stays high and hmastlock=1 for both. After hlock_1 drops, grant passes to master 0 on the next edge.
- hreset asserted mid-INCR8 (beats_left=5) on master 1, DEFAULT_MASTER=0: next cycle hgrant_0=1, hmaster=0, beats_left=0. A SINGLE request from master 1 is granted one cycle after reset deasserts.
